// File: rtl/fu_pkg.sv
// fu_pkg: ISA field, opcode and forward-code constants shared by the forwarding unit.
package fu_pkg;
  localparam int IW = 16;
  localparam int FW = 3;
  localparam int OPC_LSB = 12;
  localparam int OP1_LSB = 8;
  localparam int OP2_LSB = 4;
  localparam int FN_LSB = 0;
  localparam int FN_IMM_BIT = 3;
  localparam logic [3:0] OP_ALU = 4'h0;
  localparam logic [3:0] OP_NOP = 4'h2;
  localparam logic [3:0] OP_LW = 4'h8;
  localparam logic [3:0] OP_SW = 4'hb;
  localparam logic [3:0] FN_MULT = 4'h4;
  localparam logic [3:0] FN_DIV = 4'h5;
  localparam logic [FW-1:0] FWD_RF = 3'd0;
  localparam logic [FW-1:0] FWD_EXMEM = 3'd1;
  localparam logic [FW-1:0] FWD_MEMWB = 3'd2;
  localparam logic [FW-1:0] FWD_EXMEM_HI = 3'd3;
  localparam logic [FW-1:0] FWD_MEMWB_HI = 3'd4;
  localparam logic [FW-1:0] FWD_WB = 3'd5;
  typedef struct packed {
    logic       writes_op1;
    logic [3:0] dest;
    logic       writes_r0;
    logic       reads_a;
    logic [3:0] src_a;
    logic       reads_b;
    logic [3:0] src_b;
    logic       is_load;
  } dec_t;
  // Rules 1-4: secondary (R0) results outrank primary ones, and loads never forward from EX/MEM.
  function automatic logic [FW-1:0] fwd_sel(input logic rd, input logic [3:0] src, input dec_t idex, input dec_t exmem);
    if (!rd) return FWD_RF;
    if (idex.writes_r0 && src == 4'd0) return FWD_EXMEM_HI;
    if (idex.writes_op1 && idex.dest == src && !idex.is_load) return FWD_EXMEM;
    if (exmem.writes_r0 && src == 4'd0) return FWD_MEMWB_HI;
    if (exmem.writes_op1 && exmem.dest == src) return FWD_MEMWB;
    return FWD_RF;
  endfunction
endpackage

// File: rtl/fu_decode.sv
// fu_decode: maps one instruction to its register reads and writes; unknown opcodes read and write nothing.
module fu_decode
  import fu_pkg::*;
(
  input  logic [IW-1:0] ir,
  output dec_t          d
);
  logic [3:0] opc, op1, op2, fn;
  logic       md;
  assign opc = ir[OPC_LSB +: 4];
  assign op1 = ir[OP1_LSB +: 4];
  assign op2 = ir[OP2_LSB +: 4];
  assign fn  = ir[FN_LSB +: 4];
  assign md  = fn == FN_MULT || fn == FN_DIV;
  always_comb begin
    d = '0;
    case (opc)
      OP_ALU: begin
        d.writes_op1 = 1'b1;
        d.dest       = op1;
        d.writes_r0  = md;
        d.reads_a    = 1'b1;
        d.src_a      = op1;
        d.reads_b    = !fn[FN_IMM_BIT];
        d.src_b      = op2;
      end
      OP_LW: begin
        d.writes_op1 = 1'b1;
        d.dest       = op1;
        d.reads_a    = 1'b1;
        d.src_a      = op2;
        d.is_load    = 1'b1;
      end
      OP_SW: begin
        d.reads_a = 1'b1;
        d.src_a   = op2;
        d.reads_b = 1'b1;
        d.src_b   = op1;
      end
      default: d = '0;
    endcase
  end
endmodule

// File: rtl/forwarding_unit.sv
// forwarding_unit: registered ALU operand forward selects; FU_WB_BYPASS_EN adds the MEM/WB bypass (code 5).
module forwarding_unit
  import fu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] IFIDIR,
  input  logic [IW-1:0] IDEXIR,
  input  logic [IW-1:0] EXMEMIR,
  input  logic [IW-1:0] MEMWBIR,
  output logic [FW-1:0] ForwardA,
  output logic [FW-1:0] ForwardB
);
  dec_t ifid, idex, exmem;
  logic [FW-1:0] fa, fb;
  logic unused_dec;
  fu_decode u_ifid  (.ir(IFIDIR),  .d(ifid));
  fu_decode u_idex  (.ir(IDEXIR),  .d(idex));
  fu_decode u_exmem (.ir(EXMEMIR), .d(exmem));
`ifdef FU_WB_BYPASS_EN
  dec_t memwb;
  logic [FW-1:0] ba, bb;
  fu_decode u_memwb (.ir(MEMWBIR), .d(memwb));
  assign ba = fwd_sel(ifid.reads_a, ifid.src_a, idex, exmem);
  assign bb = fwd_sel(ifid.reads_b, ifid.src_b, idex, exmem);
  // Only reached when nothing younger claimed the register.
  assign fa = (ifid.reads_a && ba == FWD_RF && ((memwb.writes_op1 && memwb.dest == ifid.src_a) || (memwb.writes_r0 && ifid.src_a == 4'd0))) ? FWD_WB : ba;
  assign fb = (ifid.reads_b && bb == FWD_RF && ((memwb.writes_op1 && memwb.dest == ifid.src_b) || (memwb.writes_r0 && ifid.src_b == 4'd0))) ? FWD_WB : bb;
  assign unused_dec = ^{ifid.writes_op1, ifid.dest, ifid.writes_r0, ifid.is_load,
                        idex.reads_a, idex.src_a, idex.reads_b, idex.src_b,
                        exmem.reads_a, exmem.src_a, exmem.reads_b, exmem.src_b,
                        memwb.reads_a, memwb.src_a, memwb.reads_b, memwb.src_b, memwb.is_load};
`else
  assign fa = fwd_sel(ifid.reads_a, ifid.src_a, idex, exmem);
  assign fb = fwd_sel(ifid.reads_b, ifid.src_b, idex, exmem);
  assign unused_dec = ^{ifid.writes_op1, ifid.dest, ifid.writes_r0, ifid.is_load,
                        idex.reads_a, idex.src_a, idex.reads_b, idex.src_b,
                        exmem.reads_a, exmem.src_a, exmem.reads_b, exmem.src_b, MEMWBIR};
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      ForwardA <= FWD_RF;
      ForwardB <= FWD_RF;
    end else begin
      ForwardA <= fa;
      ForwardB <= fb;
    end
  end
endmodule

// File: tb/tb_forwarding_unit.sv
// tb_forwarding_unit: directed and randomized checks of forwarding_unit against a register-mask reference model.
module tb_forwarding_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IFIDIR, IDEXIR, EXMEMIR, MEMWBIR;
  logic [2:0]  ForwardA, ForwardB;
  int          n_checks = 0;
  int          n_errors = 0;
`ifdef FU_WB_BYPASS_EN
  localparam int WBX = 5;
`else
  localparam int WBX = 0;
`endif

  forwarding_unit dut (
    .clk(clk), .rst(rst), .IFIDIR(IFIDIR), .IDEXIR(IDEXIR), .EXMEMIR(EXMEMIR),
    .MEMWBIR(MEMWBIR), .ForwardA(ForwardA), .ForwardB(ForwardB)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] got, input int exp);
    n_checks++;
    if (got !== 3'(exp)) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (ifid=%h idex=%h exmem=%h memwb=%h)",
               tag, got, exp, IFIDIR, IDEXIR, EXMEMIR, MEMWBIR);
    end
  endtask

  // Register number read on an operand, or -1 when that operand reads nothing.
  function automatic int src_of(input logic [15:0] ir, input bit b);
    case (ir[15:12])
      4'h0: return b ? (ir[3] ? -1 : int'(ir[7:4])) : int'(ir[11:8]);
      4'h8: return b ? -1 : int'(ir[7:4]);
      4'hb: return b ? int'(ir[11:8]) : int'(ir[7:4]);
      default: return -1;
    endcase
  endfunction

  function automatic logic [15:0] prim_mask(input logic [15:0] ir);
    return (ir[15:12] == 4'h0 || ir[15:12] == 4'h8) ? 16'(1) << ir[11:8] : 16'h0;
  endfunction

  function automatic bit writes_hi(input logic [15:0] ir);
    return ir[15:12] == 4'h0 && (ir[3:0] == 4'h4 || ir[3:0] == 4'h5);
  endfunction

  function automatic int model(input logic [15:0] ifid, idex, exmem, memwb, input bit b);
    int s;
    logic [15:0] m_idex, m_exmem, m_memwb;
    s = src_of(ifid, b);
    m_idex = prim_mask(idex);
    m_exmem = prim_mask(exmem);
    m_memwb = prim_mask(memwb);
    if (s < 0) return 0;
    if (writes_hi(idex) && s == 0) return 3;
    if (m_idex[s] && idex[15:12] != 4'h8) return 1;
    if (writes_hi(exmem) && s == 0) return 4;
    if (m_exmem[s]) return 2;
    if (WBX != 0 && (m_memwb[s] || (writes_hi(memwb) && s == 0))) return WBX;
    return 0;
  endfunction

  task automatic tick(input string tag, input logic r, input logic [15:0] ifid, idex, exmem, memwb,
                      input int ea, input int eb);
    rst = r; IFIDIR = ifid; IDEXIR = idex; EXMEMIR = exmem; MEMWBIR = memwb;
    @(posedge clk);
    #1;
    check({tag, ".A"}, ForwardA, ea);
    check({tag, ".B"}, ForwardB, eb);
  endtask

  function automatic logic [15:0] rand_ir();
    logic [3:0] opc;
    int k;
    k = int'($urandom_range(0, 5));
    opc = (k == 0 || k == 1) ? 4'h0 : (k == 2) ? 4'h2 : (k == 3) ? 4'h8 : (k == 4) ? 4'hb : 4'($urandom);
    return {opc, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom)};
  endfunction

  initial begin
    logic [15:0] a, b, c, d;
    logic r;
    rst = 1'b1; IFIDIR = 16'h2000; IDEXIR = 16'h2000; EXMEMIR = 16'h2000; MEMWBIR = 16'h2000;
    @(negedge clk);
    tick("rst_hold",   1'b1, 16'h0351, 16'h0340, 16'h2000, 16'h2000, 0, 0);
    tick("rst_rel",    1'b0, 16'h0351, 16'h0340, 16'h2000, 16'h2000, 1, 0);
    tick("exmem_b",    1'b0, 16'h0135, 16'h2000, 16'h0340, 16'h2000, 0, 2);
    tick("div_hi_ex",  1'b0, 16'h0a00, 16'h0b05, 16'h2000, 16'h2000, 0, 3);
    tick("div_hi_mem", 1'b0, 16'h0a00, 16'h2000, 16'h0b05, 16'h2000, 0, 4);
    tick("load_use",   1'b0, 16'h09b0, 16'h89a3, 16'h2000, 16'h2000, 0, 0);
    tick("load_mem",   1'b0, 16'h09b0, 16'h2000, 16'h89a3, 16'h2000, 2, 0);
    tick("priority",   1'b0, 16'h0330, 16'h0340, 16'h0300, 16'h2000, 1, 1);
    tick("imm",        1'b0, 16'h0538, 16'h0340, 16'h0300, 16'h2000, 0, 0);
    tick("wb_bypass",  1'b0, 16'h0351, 16'h2000, 16'h2000, 16'h0340, WBX, 0);
    tick("sw",         1'b0, 16'hb340, 16'h0440, 16'h0300, 16'h2000, 1, 2);
    tick("mul_r0",     1'b0, 16'h0000, 16'h0004, 16'h2000, 16'h2000, 3, 3);
    tick("rst_mid",    1'b1, 16'h0330, 16'h0340, 16'h0300, 16'h2000, 0, 0);
    tick("rst_after",  1'b0, 16'h0330, 16'h0340, 16'h0300, 16'h2000, 1, 1);
    for (int i = 0; i < 400; i++) begin
      a = rand_ir(); b = rand_ir(); c = rand_ir(); d = rand_ir();
      r = ($urandom_range(0, 15) == 0);
      tick("rand", r, a, b, c, d, r ? 0 : model(a, b, c, d, 1'b0), r ? 0 : model(a, b, c, d, 1'b1));
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/forwarding_unit.md
Name: forwarding_unit

Overview:
Data-forwarding select generator for the 16-bit, 5-stage pipelined CPU. It decodes the instruction in IF/ID (the consumer) against the older instructions in ID/EX, EX/MEM and MEM/WB (the producers). It registers 3-bit mux selects for the two EX-stage ALU operand muxes, so the selects are aligned with the consumer when it enters EX. The block is pure decode/compare logic plus one output register stage.

Parameters:
IW, 16, instruction width (fixed ISA; not meant to be overridden)
FW, 3, forward-select width

Ports:
clk  in  1  system clock; the only clock
rst  in  1  reset, synchronous, active-high
IFIDIR  in  16  instruction in IF/ID (consumer)
IDEXIR  in  16  instruction in ID/EX
EXMEMIR  in  16  instruction in EX/MEM
MEMWBIR  in  16  instruction in MEM/WB
ForwardA  out  3  select for ALU operand A mux (registered)
ForwardB  out  3  select for ALU operand B mux (registered)

Behaviour:
- Instruction fields: [15:12] opcode, [11:8] Op1, [7:4] Op2, [3:0] func (or imm4 for load/store).
- Opcode 0, ALU: writes Op1; reads Op1 on A.
  - func[3]=0: also reads Op2 on B.
  - func[3]=1 (immediate form): Op2 is an immediate; nothing is read on B.
  - func 4 = MULT, func 5 = DIV: write Op1 (low/quotient) and R0 (high/remainder).
- Opcode 8, LW: writes Op1; reads Op2 (base) on A; nothing on B.
- Opcode B, SW: reads Op2 (base) on A and Op1 (data) on B; writes nothing.
- All other opcodes (including 2 = NOP, 'h2000): read nothing, write nothing.
- Forward codes:
  - 0: register file
  - 1: EX/MEM primary result
  - 2: MEM/WB primary result (ALU or load data)
  - 3: EX/MEM secondary (R0 high) result
  - 4: MEM/WB secondary result
  - 5: WB bypass latch (optional feature only)
  - 6 and 7: never generated.
- Per operand X in {A, B}: if the consumer does not read X, the code is 0. Otherwise the first match in this order wins:
  1. IDEXIR is MULT/DIV and srcX==0 -> 3
  2. IDEXIR writes Op1==srcX and is not LW -> 1
  3. EXMEMIR is MULT/DIV and srcX==0 -> 4
  4. EXMEMIR writes Op1==srcX -> 2
  5. optional MEMWBIR rule (see Optional Feature)
  6. otherwise 0
- Secondary (R0) results beat primary results when a MULT/DIV has Op1==0.
- A load in IDEXIR is never forwarded from EX/MEM. The load-use stall belongs to the hazard unit; after the stall the load sits in EXMEMIR and yields code 2.
- R0 is an ordinary register otherwise; writes to R0 are forwarded like any other register.
- Timing: on each rising clk edge, ForwardA/ForwardB <= the codes computed from the current inputs. Latency is exactly 1 cycle, with no enable; a stalled IF/ID simply recomputes.
- rst=1 at an edge sets ForwardA=ForwardB=0. rst takes priority over new codes, including mid-stream; the first valid codes appear one edge after rst is deasserted.
- X/undefined opcodes decode as "no read, no write".

Optional Feature:
- Macro: FU_WB_BYPASS_EN.
- When defined, MEMWBIR is decoded as a producer at rule 5: any write to srcX (Op1, or R0 for MULT/DIV) -> code 5. This serves register files without write-through.
- When undefined, MEMWBIR is ignored (port kept, unused) and code 5 is never produced.

Decomposition:
- Package fu_pkg holds:
  - opcode constants: OP_ALU=0, OP_NOP=2, OP_LW=8, OP_SW=B
  - func constants: FN_MULT=4, FN_DIV=5, immediate bit 3
  - field bit positions
  - forward-code constants FWD_RF..FWD_WB
- One sub-module, fu_decode: maps one IR to writes_op1, dest, writes_r0, reads_a, src_a, reads_b, src_b, is_load.
- fu_decode is instantiated once per IR port.

Test Plan:
- rst=1 with IDEXIR='h0340, IFIDIR='h0351 -> after edge ForwardA=0, ForwardB=0. Release rst -> next edge ForwardA=1, ForwardB=0.
- EXMEMIR='h0340, IDEXIR='h2000, IFIDIR='h0135 -> ForwardA=0, ForwardB=2.
- IDEXIR='h0b05 (DIV R11,R0), IFIDIR='h0a00 -> ForwardA=0, ForwardB=3. Shift so EXMEMIR='h0b05, IDEXIR='h2000 -> ForwardB=4.
- Load-use: IDEXIR='h89a3, IFIDIR='h09b0 -> ForwardA=0. Next cycle EXMEMIR='h89a3, IDEXIR='h2000, IFIDIR='h09b0 -> ForwardA=2.
- Priority/immediate: IDEXIR='h0340, EXMEMIR='h0300, IFIDIR='h0330 -> A=1, B=1. With IFIDIR='h0538 (immediate) -> B=0.
- MEMWBIR='h0340, others 'h2000, IFIDIR='h0351 -> ForwardA=5 with FU_WB_BYPASS_EN defined, 0 without.
